// File: rtl/mldsa_pkg.sv
// Shared ML-DSA constants and types for the hint packing/unpacking blocks.
//   K          : number of hint polynomials
//   OMEGA      : maximum total number of set hint bits
//   hint_arr_t : K x 256 hint bit array, h[i][j]
//   hint_field_t : encoded (OMEGA+K)-byte field; byte n = y[8n +: 8], y[8n] is the MSB
package mldsa_pkg;

    localparam int unsigned K      = 8;
    localparam int unsigned OMEGA  = 75;
    localparam int unsigned YBYTES = OMEGA + K;
    localparam int unsigned YW     = YBYTES * 8;
    // Polynomial counter width; one spare bit beyond what indexes 0..K-1.
    localparam int unsigned IW     = $clog2(K) + 1;

    typedef logic [0:K-1][0:255] hint_arr_t;
    typedef logic [0:YW-1]       hint_field_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFinish
    } hintpack_state_t;

endpackage

// File: rtl/hint_bit_pack.sv
// Sequential HintBitPack encoder: scans the K x 256 hint array one coefficient per
// cycle and builds the OMEGA+K byte hint field (positions, then cumulative counts).
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   start_i  : request, sampled only while idle
//   h_i      : hint bits, captured on the accepting edge
//   y_o      : encoded field
//   busy_o   : high from accept until done
//   done_o   : one-cycle completion pulse
//   valid_o  : y_o holds a legal encoding (held until next accept)
//   error_o  : more than OMEGA set bits (held until next accept)
module hint_bit_pack
    import mldsa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  hint_arr_t   h_i,
    output hint_field_t y_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        valid_o,
    output logic        error_o
);

    hintpack_state_t state_q;
    hint_arr_t       h_q;
    hint_field_t     y_q;
    logic [IW-1:0]   i_q;
    logic [7:0]      j_q;
    logic [7:0]      idx_q;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;
    logic            error_q;

    logic       bit_b;
    logic       hit;
    logic       ovf;
    logic       last_j;
    logic       last_i;
    logic [7:0] idx_nxt;

    always_comb begin
        bit_b   = h_q[i_q[IW-2:0]][j_q];
        hit     = bit_b && (idx_q < 8'(OMEGA));
        ovf     = bit_b && (idx_q == 8'(OMEGA));
        last_j  = (j_q == 8'd255);
        last_i  = (i_q == IW'(K - 1));
        // Count written at the end of a polynomial includes this cycle's hit.
        idx_nxt = hit ? idx_q + 8'd1 : idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            h_q     <= '0;
            y_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        h_q     <= h_i;
                        y_q     <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (ovf) begin
                        // Overflow wipes the field; nothing else is written this scan.
                        error_q <= 1'b1;
                        y_q     <= '0;
                        state_q <= StFinish;
                    end else begin
                        if (hit) begin
                            y_q[int'(idx_q) * 8 +: 8] <= j_q;
                        end
                        idx_q <= idx_nxt;
                        if (last_j) begin
                            y_q[(int'(OMEGA) + int'(i_q)) * 8 +: 8] <= idx_nxt;
                            j_q <= '0;
                            if (last_i) begin
                                state_q <= StFinish;
                            end else begin
                                i_q <= i_q + IW'(1);
                            end
                        end else begin
                            j_q <= j_q + 8'd1;
                        end
                    end
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    valid_q <= !error_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign y_o     = y_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign valid_o = valid_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_hint_bit_pack.sv
// Scoreboard bench for hint_bit_pack: expected encodings are pushed on accept and
// checked against the DUT on each done pulse, with a round trip through an unpacker.
module tb_hint_bit_pack;
    import mldsa_pkg::*;

    localparam int CW = 1024;

    typedef struct {
        hint_arr_t   h;
        hint_field_t y;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    hint_arr_t   h_in = '0;
    hint_field_t y;
    logic        busy;
    logic        done;
    logic        valid;
    logic        error;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hint_bit_pack dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .h_i     (h_in),
        .y_o     (y),
        .busy_o  (busy),
        .done_o  (done),
        .valid_o (valid),
        .error_o (error)
    );

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference encoder straight from the HintBitPack definition.
    function automatic void ref_enc(input hint_arr_t h, output hint_field_t yr,
                                    output bit err, output int lat);
        int idx = 0;
        yr  = '0;
        err = 1'b0;
        lat = K * 256 + 1;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < 256; j++) begin
                if (h[i][j]) begin
                    if (idx < OMEGA) begin
                        yr[idx * 8 +: 8] = 8'(j);
                        idx++;
                    end else begin
                        err = 1'b1;
                        yr  = '0;
                        lat = i * 256 + j + 2;
                        return;
                    end
                end
            end
            yr[(OMEGA + i) * 8 +: 8] = 8'(idx);
        end
    endfunction

    // HintBitUnpack with all its malformed-encoding checks.
    function automatic bit unpack(input hint_field_t yv, output hint_arr_t hr);
        int idx = 0;
        int c;
        int first;
        hr = '0;
        for (int i = 0; i < K; i++) begin
            c = int'(yv[(OMEGA + i) * 8 +: 8]);
            if (c < idx || c > OMEGA) return 1'b0;
            first = idx;
            while (idx < c) begin
                if (idx > first && yv[(idx - 1) * 8 +: 8] >= yv[idx * 8 +: 8]) return 1'b0;
                hr[i][yv[idx * 8 +: 8]] = 1'b1;
                idx++;
            end
        end
        for (int n = idx; n < OMEGA; n++) begin
            if (yv[n * 8 +: 8] != 8'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t      e;
        hint_arr_t hr;
        bit        ok;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", CW'(done), CW'(0));
            end else begin
                e = sb.pop_front();
                check("latency", CW'(cyc - e.acc), CW'(e.lat));
                check("y", CW'(y), CW'(e.y));
                check("error", CW'(error), CW'(e.err));
                check("valid", CW'(valid), CW'(!e.err));
                check("busy_at_done", CW'(busy), CW'(0));
                if (!e.err) begin
                    ok = unpack(y, hr);
                    check("rt_valid", CW'(ok), CW'(1));
                    check("rt_h", CW'(hr), CW'(e.h));
                end
            end
        end
    end

    task automatic run(input hint_arr_t hv);
        exp_t e;
        h_in = hv;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        e.h = hv;
        ref_enc(hv, e.y, e.err, e.lat);
        e.acc = cyc;
        sb.push_back(e);
        check("busy_after_accept", CW'(busy), CW'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", CW'(sb.size()), CW'(0));
            sb.delete();
        end
    endtask

    function automatic hint_arr_t rand_h();
        hint_arr_t hv = '0;
        int n = $urandom_range(0, 75);
        repeat (n) hv[$urandom_range(0, K - 1)][$urandom_range(0, 255)] = 1'b1;
        return hv;
    endfunction

    initial begin
        hint_arr_t hv;

        repeat (3) @(negedge clk);
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_done", CW'(done), CW'(0));
        check("rst_valid", CW'(valid), CW'(0));
        check("rst_error", CW'(error), CW'(0));
        check("rst_y", CW'(y), CW'(0));
        rst = 1'b0;
        @(negedge clk);

        // All-zero hints.
        run('0);
        wait_done();
        check("zero_y", CW'(y), CW'(0));

        // Single bit at h[0][5].
        hv = '0;
        hv[0][5] = 1'b1;
        run(hv);
        wait_done();
        check("one_b0", CW'(y[0 +: 8]), CW'(5));
        check("one_b1", CW'(y[8 +: 8]), CW'(0));
        check("one_b75", CW'(y[75 * 8 +: 8]), CW'(1));
        check("one_b82", CW'(y[82 * 8 +: 8]), CW'(1));

        // Segment edges: h[0][0], h[0][255], h[7][17].
        hv = '0;
        hv[0][0]   = 1'b1;
        hv[0][255] = 1'b1;
        hv[7][17]  = 1'b1;
        run(hv);
        wait_done();
        check("edge_b1", CW'(y[8 +: 8]), CW'(255));
        check("edge_b2", CW'(y[16 +: 8]), CW'(17));
        check("edge_b81", CW'(y[81 * 8 +: 8]), CW'(2));
        check("edge_b82", CW'(y[82 * 8 +: 8]), CW'(3));

        // Exactly OMEGA set bits.
        hv = '0;
        for (int n = 0; n < 75; n++) hv[0][n] = 1'b1;
        run(hv);
        wait_done();
        check("full_b74", CW'(y[74 * 8 +: 8]), CW'(74));
        check("full_b82", CW'(y[82 * 8 +: 8]), CW'(75));
        check("full_valid", CW'(valid), CW'(1));

        // OMEGA+1 set bits: overflow.
        hv[0][75] = 1'b1;
        run(hv);
        wait_done();
        repeat (3) @(negedge clk);
        check("ovf_error_held", CW'(error), CW'(1));
        check("ovf_valid_held", CW'(valid), CW'(0));
        check("ovf_y", CW'(y), CW'(0));

        // Reset mid-scan: no done pulse, everything back to reset values.
        hv = '0;
        for (int n = 0; n < 40; n++) hv[n % K][(n * 7) % 256] = 1'b1;
        run(hv);
        repeat (299) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", CW'(busy), CW'(0));
        check("mid_rst_y", CW'(y), CW'(0));
        check("mid_rst_done", CW'(done), CW'(0));
        check("mid_rst_valid", CW'(valid), CW'(0));
        sb.delete();
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);

        // Next start after reset completes normally.
        run(hv);
        wait_done();

        // Start pulsed while busy (with new h) is ignored.
        run(rand_h());
        repeat (100) @(negedge clk);
        h_in  = rand_h();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        check("busy_idle_after_ignored", CW'(busy), CW'(0));

        // Random round trips.
        for (int r = 0; r < 4; r++) begin
            run(rand_h());
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
